mod_sub_256_seq: RTL and testbench
==================================

// Module: mod_sub_256_seq
// PURPOSE
//   Sequential 256-bit modular subtractor for the ECC field datapath: R = (A - B) mod P.
//   Processes one W-bit limb per cycle, LS limb first.
//   Pass 1 computes A - B with a chained borrow.
//   Pass 2 always adds (P AND borrow-mask) with a chained carry, so latency is fixed
//   (constant-time, no data-dependent timing).
//   Sits upstream of the W-bit limb subtractor/adder and drives it.
// PARAMETERS
//   W  64  limb width in bits; must match the limb subtractor width
//   N  4   number of limbs; operand width is W*N = 256
// PORTS
//   clk      in   1    system clock, rising edge
//   rst      in   1    asynchronous, active-high reset
//   start    in   1    request; sampled only while idle (busy=0)
//   a        in   W*N  minuend, must satisfy a < p
//   b        in   W*N  subtrahend, must satisfy b < p
//   p        in   W*N  field modulus
//   busy     out  1    high from the cycle after an accepted start through the done cycle
//   done     out  1    one-cycle pulse; result and wrapped are valid
//   result   out  W*N  (a - b) mod p; held until the next accepted start
//   wrapped  out  1    1 if a < b (correction pass added p); held with result
// BEHAVIOUR
//   Reset (async): state=IDLE, limb counter=0, borrow/carry=0, busy=0, done=0,
//     result=0, wrapped=0. Reset mid-operation aborts the operation; nothing resumes.
//   FSM: IDLE -> SUB -> CORR -> DONE -> IDLE.
//   IDLE: on start=1 at edge t0, latch a, b, p into internal registers, set counter=0,
//     clear borrow, go to SUB. Later changes on a, b, p are ignored.
//   SUB: edges t0+1..t0+N, one per limb k = counter.
//     {borrow, d[k]} = A[k] - B[k] - borrow.
//     After limb N-1: wrapped <= borrow, mask = {W{borrow}}, counter=0, carry=0, go to CORR.
//   CORR: edges t0+N+1..t0+2N.
//     {carry, r[k]} = d[k] + (P[k] & mask) + carry.
//     After limb N-1: the final carry is discarded (mod 2^(W*N)), go to DONE.
//   DONE: done=1 and busy=1 for exactly the one cycle after edge t0+2N. The next edge
//     returns to IDLE. done therefore appears 2N+1 cycles after the start edge
//     (9 cycles for N=4), independent of the data.
//   result is updated only at the DONE transition; wrapped is updated at the end of SUB.
//   start while busy=1, including the DONE cycle, is ignored and not queued.
//   start may be asserted in the first IDLE cycle after DONE (back-to-back throughput
//     of 2N+2 cycles).
//   Operands must satisfy a, b < p. Out-of-range inputs give result = (a - b + wrapped*p)
//     mod 2^(W*N); no error is flagged.
//   Internal arithmetic uses W+1-bit intermediates; borrow and carry cross limb
//     boundaries only through the registered borrow/carry bit.
// TESTING
//   1. a=5, b=3, p=7 -> result=2, wrapped=0, done exactly 9 cycles after the start edge.
//   2. a=3, b=5, p=7 -> result=5, wrapped=1, same latency as test 1 (constant time).
//   3. a=2^64, b=1, p=P-256 prime -> result=0x0..0_FFFFFFFFFFFFFFFF
//      (borrow ripples across the limb boundary), wrapped=0.
//   4. a=0, b=p-1, p=P-256 prime -> result=1, wrapped=1; a=b=p-1 -> result=0, wrapped=0.
//   5. Pulse start again 3 cycles into an operation, with different a/b
//      -> ignored; the first result is unchanged, and a single done pulse occurs.
//   6. Assert rst during CORR -> busy, done, result and wrapped go to 0 immediately;
//      no done pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/mod_sub_256_seq_if.sv
// rtl/mod_sub_256_seq_if.sv - request/result bundle for the sequential modular subtractor
interface mod_sub_256_seq_if #(
    parameter int W = 64,
    parameter int N = 4
);
    logic             start;
    logic [W*N-1:0]   a;
    logic [W*N-1:0]   b;
    logic [W*N-1:0]   p;
    logic             busy;
    logic             done;
    logic [W*N-1:0]   result;
    logic             wrapped;

    modport master (output start, a, b, p, input busy, done, result, wrapped);
    modport slave  (input start, a, b, p, output busy, done, result, wrapped);
endinterface

// File: rtl/mod_sub_256_seq.sv
// rtl/mod_sub_256_seq.sv - constant-time limb-serial (a - b) mod p
module mod_sub_256_seq #(
    parameter int W = 64,
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    mod_sub_256_seq_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_CORR, S_DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [W*N-1:0]   a_r, b_r, p_r;
    logic             borrow, carry, mask;
    logic [W*N-1:0]   result_r;
    logic             wrapped_r;
    logic             last;
    logic [W:0]       diff;
    logic [W:0]       sum;
    logic [W*N-1:0]   corr_full;

    assign last = (cnt == CW'(N - 1));

    // a_r holds the operand, then the difference d, then the corrected limbs in place
    assign diff = {1'b0, a_r[cnt*W +: W]} - {1'b0, b_r[cnt*W +: W]} - {{W{1'b0}}, borrow};
    assign sum  = {1'b0, a_r[cnt*W +: W]} + {1'b0, p_r[cnt*W +: W] & {W{mask}}}
                + {{W{1'b0}}, carry};

    always_comb begin
        corr_full = a_r;
        corr_full[cnt*W +: W] = sum[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.start) state_nx = S_SUB;
            S_SUB:  if (last)      state_nx = S_CORR;
            S_CORR: if (last)      state_nx = S_DONE;
            S_DONE:                state_nx = S_IDLE;
            default:               state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            p_r       <= '0;
            borrow    <= 1'b0;
            carry     <= 1'b0;
            mask      <= 1'b0;
            result_r  <= '0;
            wrapped_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    a_r    <= bus.a;
                    b_r    <= bus.b;
                    p_r    <= bus.p;
                    cnt    <= '0;
                    borrow <= 1'b0;
                end
                S_SUB: begin
                    a_r[cnt*W +: W] <= diff[W-1:0];
                    borrow          <= diff[W];
                    if (last) begin
                        wrapped_r <= diff[W];
                        mask      <= diff[W];
                        carry     <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_CORR: begin
                    a_r[cnt*W +: W] <= sum[W-1:0];
                    carry           <= sum[W];
                    if (last) begin
                        // final carry out is dropped: result is mod 2^(W*N)
                        result_r <= corr_full;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE);
    assign bus.result  = result_r;
    assign bus.wrapped = wrapped_r;
endmodule

// File: tb/tb_mod_sub_256_seq.sv
// tb/tb_mod_sub_256_seq.sv - self-checking bench for mod_sub_256_seq
module tb_mod_sub_256_seq;
    localparam int W = 64;
    localparam int N = 4;
    localparam int LAT = 2 * N + 1;
    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mod_sub_256_seq_if #(.W(W), .N(N)) bus ();

    mod_sub_256_seq #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // intr_at > 0 pulses start (with different operands) that many cycles into the op
    task automatic run_op(input logic [255:0] ta, input logic [255:0] tb_, input logic [255:0] tp,
                          input int intr_at, input string tag);
        logic [255:0] er;
        logic         ew;
        int           cnt;
        int           extra;
        ew = (ta < tb_);
        er = ta - tb_ + (ew ? tp : 256'd0);
        @(negedge clk);
        bus.a = ta; bus.b = tb_; bus.p = tp; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = ~ta; bus.b = ~tb_ ^ 256'h5; bus.p = ~tp;
        cnt = 1;
        while (bus.done !== 1'b1 && cnt < 40) begin
            bus.start = (cnt == intr_at);
            @(posedge clk); #1;
            cnt++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 256'(cnt), 256'(LAT));
        check({tag, "_busy_done"}, {255'b0, bus.busy}, 256'd1);
        check({tag, "_result"}, bus.result, er);
        check({tag, "_wrapped"}, {255'b0, bus.wrapped}, {255'b0, ew});
        extra = 0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra++;
        end
        check({tag, "_single_done"}, 256'(extra), 256'd0);
        check({tag, "_idle_after"}, {255'b0, bus.busy}, 256'd0);
        check({tag, "_result_held"}, bus.result, er);
    endtask

    initial begin
        logic [255:0] rp, ra, rb;
        int           cnt;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0; bus.b = '0; bus.p = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {255'b0, bus.busy}, 256'd0);
        check("reset_done", {255'b0, bus.done}, 256'd0);
        check("reset_result", bus.result, 256'd0);
        check("reset_wrapped", {255'b0, bus.wrapped}, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(256'd5, 256'd3, 256'd7, 0, "t1");
        run_op(256'd3, 256'd5, 256'd7, 0, "t2");
        run_op(256'h1_0000000000000000, 256'd1, P256, 0, "t3");
        run_op(256'd0, P256 - 256'd1, P256, 0, "t4a");
        run_op(P256 - 256'd1, P256 - 256'd1, P256, 0, "t4b");
        run_op(256'd1234, 256'd99, P256, 3, "t5");

        // reset during the correction pass
        @(negedge clk);
        bus.a = 256'd3; bus.b = 256'd5; bus.p = 256'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 1;
        while (cnt < N + 2) begin
            @(posedge clk); #1;
            cnt++;
        end
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {255'b0, bus.busy}, 256'd0);
        check("rst_mid_done", {255'b0, bus.done}, 256'd0);
        check("rst_mid_result", bus.result, 256'd0);
        check("rst_mid_wrapped", {255'b0, bus.wrapped}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) cnt++;
        end
        check("rst_mid_no_done", 256'(cnt), 256'd0);
        run_op(256'd5, 256'd3, 256'd7, 0, "t6_fresh");

        for (int i = 0; i < 12; i++) begin
            rp = rand256();
            rp[255] = 1'b1;
            ra = rand256() % rp;
            rb = rand256() % rp;
            run_op(ra, rb, rp, 0, $sformatf("rand%0d", i));
        end
        // out-of-range operands: no error, same modular formula
        run_op(rand256(), rand256(), rand256(), 0, "oor");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
